// File: rtl/exec_ctrl.sv
// Multi-cycle fetch/decode/execute sequencer for the 8-bit core.
// Optional fetch watchdog enabled by defining CTRL_TIMEOUT_EN.
module exec_ctrl #(
  parameter int unsigned FETCH_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic [7:0]  start_addr_i,
  output logic        busy_o,
  output logic        halted_o,
  output logic        retired_o,
  output logic [7:0]  pc_o,
  output logic        imem_req_o,
  output logic [7:0]  imem_addr_o,
  input  logic        imem_ack_i,
  input  logic [15:0] imem_data_i,
  output logic [2:0]  rf_src1_o,
  output logic [2:0]  rf_src2_o,
  output logic [2:0]  rf_dst_o,
  output logic        rf_we_o,
  output logic [7:0]  rf_wdata_o,
  input  logic [7:0]  rf_data1_i,
  input  logic [7:0]  rf_data2_i,
  output logic [3:0]  alu_op_o,
  output logic [7:0]  alu_in1_o,
  output logic [7:0]  alu_in2_o,
  input  logic [7:0]  alu_result_i,
  input  logic        alu_branch_i,
  output logic        fault_o
);

`ifdef CTRL_TIMEOUT_EN
  localparam logic TO_EN = 1'b1;
`else
  localparam logic TO_EN = 1'b0;
`endif

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_READ, S_EXEC, S_WB, S_HALT
  } state_t;

  state_t      state_q;
  logic [7:0]  pc_q;
  logic [15:0] instr_q;
  logic        busy_q, halted_q, retired_q, req_q, we_q, branch_q, fault_q;
  logic [2:0]  src1_q, src2_q, dst_q;
  logic [7:0]  wdata_q, in1_q, in2_q, cnt_q;
  logic [3:0]  aluop_q;

  logic [3:0] op;
  logic       is_alu, is_br, is_incdec, is_halt;

  always_comb begin
    op        = instr_q[15:12];
    is_alu    = (op <= 4'd5);
    is_br     = (op == 4'd6) || (op == 4'd7) || (op == 4'd8);
    is_incdec = (op == 4'd4) || (op == 4'd5);
    is_halt   = (op == 4'd15);
  end

  // Every output is a register loaded on entry to the state that owns it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      pc_q      <= '0;
      instr_q   <= '0;
      busy_q    <= 1'b0;
      halted_q  <= 1'b0;
      retired_q <= 1'b0;
      req_q     <= 1'b0;
      we_q      <= 1'b0;
      branch_q  <= 1'b0;
      fault_q   <= 1'b0;
      src1_q    <= '0;
      src2_q    <= '0;
      dst_q     <= '0;
      wdata_q   <= '0;
      in1_q     <= '0;
      in2_q     <= '0;
      aluop_q   <= '0;
      cnt_q     <= '0;
    end else begin
      retired_q <= 1'b0;
      we_q      <= 1'b0;
      case (state_q)
        S_IDLE, S_HALT: begin
          if (start_i) begin
            pc_q     <= start_addr_i;
            state_q  <= S_FETCH;
            req_q    <= 1'b1;
            busy_q   <= 1'b1;
            halted_q <= 1'b0;
            fault_q  <= 1'b0;
            cnt_q    <= '0;
          end
        end
        S_FETCH: begin
          if (imem_ack_i) begin
            instr_q <= imem_data_i;
            src1_q  <= imem_data_i[11:9];
            src2_q  <= imem_data_i[8:6];
            req_q   <= 1'b0;
            state_q <= S_DECODE;
          end else if (TO_EN && cnt_q == 8'(FETCH_TIMEOUT - 1)) begin
            state_q  <= S_HALT;
            req_q    <= 1'b0;
            busy_q   <= 1'b0;
            halted_q <= 1'b1;
            fault_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        S_DECODE: state_q <= S_READ;
        S_READ: begin
          aluop_q <= op;
          in1_q   <= rf_data1_i;
          in2_q   <= is_incdec ? '0 : rf_data2_i;
          state_q <= S_EXEC;
        end
        S_EXEC: begin
          branch_q <= alu_branch_i;
          if (is_alu) begin
            we_q    <= 1'b1;
            dst_q   <= instr_q[5:3];
            wdata_q <= alu_result_i;
          end
          retired_q <= !is_halt;
          state_q   <= S_WB;
        end
        S_WB: begin
          if (is_halt) begin
            state_q  <= S_HALT;
            busy_q   <= 1'b0;
            halted_q <= 1'b1;
          end else begin
            pc_q    <= (is_br && branch_q) ? {2'b00, instr_q[5:0]} : pc_q + 8'd1;
            state_q <= S_FETCH;
            req_q   <= 1'b1;
            cnt_q   <= '0;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy_o      = busy_q;
  assign halted_o    = halted_q;
  assign retired_o   = retired_q;
  assign pc_o        = pc_q;
  assign imem_req_o  = req_q;
  assign imem_addr_o = pc_q;
  assign rf_src1_o   = src1_q;
  assign rf_src2_o   = src2_q;
  assign rf_dst_o    = dst_q;
  assign rf_we_o     = we_q;
  assign rf_wdata_o  = wdata_q;
  assign alu_op_o    = aluop_q;
  assign alu_in1_o   = in1_q;
  assign alu_in2_o   = in2_q;
  assign fault_o     = TO_EN & fault_q;

endmodule
